multicycle_controller: RTL
==========================

# multicycle_controller

Finite-state controller that sequences the multicycle MIPS32 datapath, where one memory port, one ALU and the register file are shared across the cycles of each instruction. It replaces the single-cycle decode path with a per-state control word. It adds a ready/request handshake to the shared instruction/data memory so that fetches and data accesses can stall for wait states. ALU operation encoding and instruction coverage match the existing single-cycle control.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26], read from the instruction register.
- funct  in  6  instr[5:0], read from the instruction register.
- zero  in  1  ALU zero flag.
- memReady  in  1  memory has completed the current access this cycle.
- memReq  out  1  memory access request.
- memWrite  out  1  memory write strobe.
- iorD  out  1  address select: 0 = PC, 1 = ALUOut.
- irWrite  out  1  instruction register load.
- pcEn  out  1  PC load.
- pcSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- regWrite  out  1  register file write.
- regDest  out  1  destination register select: 1 = rd, 0 = rt.
- memtoReg  out  1  writeback select: 1 = data register, 0 = ALUOut.
- aluSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- aluSrcB  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  out  4  current state, for debug.

## Operation
- State register: 4 bits, asynchronous reset to FETCH.
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge.
- All outputs are combinational decodes of the state (plus memReady and zero where noted). Any output not listed for a state is 0.
- FETCH: memReq=1, iorD=0, aluSrcA=0, aluSrcB=01, aluControl=010, pcSrc=00, irWrite=memReady, pcEn=memReady. Stays in FETCH until memReady=1, then goes to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluControl=010 (branch target precomputed into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other opcode → FETCH, with illegal=1.
- MEMADR: aluSrcA=1, aluSrcB=10, aluControl=010. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: memReq=1, iorD=1. Waits for memReady, then goes to MEMWB.
- MEMWB: regWrite=1, regDest=0, memtoReg=1. Goes to FETCH.
- MEMWR: memReq=1, memWrite=1, iorD=1. Waits for memReady, then goes to FETCH.
- RTYPEEX: aluSrcA=1, aluSrcB=00, aluControl from funct. Goes to RTYPEWB.
  - funct map: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other→010.
- RTYPEWB: regWrite=1, regDest=1, memtoReg=0. Goes to FETCH.
- BEQEX: aluSrcA=1, aluSrcB=00, aluControl=110, pcSrc=01, pcEn=zero. Goes to FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluControl=010. Goes to ADDIWB.
- ADDIWB: regWrite=1, regDest=0, memtoReg=0. Goes to FETCH.
- JUMP: pcSrc=10, pcEn=1. Goes to FETCH.

## Timing
- Reset:
  - While rst_n=0: state=0 (FETCH), and memReq, memWrite, irWrite, pcEn, regWrite and illegal are forced to 0 combinationally.
  - The other outputs show the FETCH decode: aluSrcB=01, aluControl=010, all remaining outputs 0.
- First fetch request is asserted in the cycle after rst_n rises.
- rst_n asserted mid-instruction aborts immediately. No partial writeback occurs after assertion.
- Cycles per instruction, with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- memReady is ignored outside FETCH, MEMRD and MEMWR.
- memWrite stays asserted for the whole time MEMWR waits. The memory must commit exactly once, on the cycle memReady=1.
- Write strobes (irWrite, pcEn, regWrite) are high for at most one cycle per instruction. The exception is pcEn, which is high exactly twice for a taken beq or a j: once in FETCH and once in the execute state.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with memReady=1 → state=0, all strobes 0. Release rst_n → memReq=1 on the next cycle; irWrite and pcEn pulse once; state=1.
- lw (opcode 100011), memReady=1 throughout → state sequence 0,1,2,3,4,0. regWrite=1 with memtoReg=1 only in state 4. Total 5 cycles.
- sw with 2 wait cycles in MEMWR → state holds at 5 for 3 cycles with memWrite=1, then returns to 0. regWrite is never 1.
- R-type funct 101010, then funct 100101 → aluControl=111, then 001, in RTYPEEX; regWrite=1 with regDest=1 in RTYPEWB.
- beq with zero=1, then zero=0 → pcEn=1 with pcSrc=01 in BEQEX for the first; pcEn=0 for the second. Both return to FETCH after 3 cycles.
- Opcode 111111 → illegal=1 for exactly one cycle in DECODE, next state FETCH, no writes. Also pull rst_n low during MEMRD → state becomes 0 asynchronously and no regWrite follows.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | multicycle_controller                                                  |
// | Per-state control word generator for the multicycle MIPS32 datapath,  |
// | with a request/ready handshake toward the shared instruction/data     |
// | memory so fetches and data accesses can absorb wait states.           |
// | Revision: 1.0                                                         |
// +------------------------------------------------------------------------+
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       iorD,
  output logic       irWrite,
  output logic       pcEn,
  output logic [1:0] pcSrc,
  output logic       regWrite,
  output logic       regDest,
  output logic       memtoReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;

  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_decode_next;
  logic [2:0] w_funct_alu;

  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_en;
  logic       w_reg_write;
  logic       w_illegal;

  // Opcode dispatch out of DECODE; unsupported opcodes fall back to FETCH.
  always_comb begin
    w_decode_next = S_FETCH;
    case (opcode)
      c_OP_LW,
      c_OP_SW:    w_decode_next = S_MEMADR;
      c_OP_RTYPE: w_decode_next = S_RTYPEEX;
      c_OP_BEQ:   w_decode_next = S_BEQEX;
      c_OP_ADDI:  w_decode_next = S_ADDIEX;
      c_OP_J:     w_decode_next = S_JUMP;
      default:    w_decode_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_funct_alu = c_ALU_ADD;
    case (funct)
      c_FN_ADD: w_funct_alu = c_ALU_ADD;
      c_FN_SUB: w_funct_alu = c_ALU_SUB;
      c_FN_AND: w_funct_alu = c_ALU_AND;
      c_FN_OR:  w_funct_alu = c_ALU_OR;
      c_FN_SLT: w_funct_alu = c_ALU_SLT;
      default:  w_funct_alu = c_ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   r_state <= memReady ? S_DECODE : S_FETCH;
        S_DECODE:  r_state <= w_decode_next;
        S_MEMADR:  r_state <= (opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   r_state <= memReady ? S_MEMWB : S_MEMRD;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   r_state <= memReady ? S_FETCH : S_MEMWR;
        S_RTYPEEX: r_state <= S_RTYPEWB;
        S_RTYPEWB: r_state <= S_FETCH;
        S_BEQEX:   r_state <= S_FETCH;
        S_ADDIEX:  r_state <= S_ADDIWB;
        S_ADDIWB:  r_state <= S_FETCH;
        S_JUMP:    r_state <= S_FETCH;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Control word decode. Unused state codes decode like FETCH for the
  // steering fields but issue no request and no strobes.
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_en     = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    iorD        = 1'b0;
    pcSrc       = 2'b00;
    regDest     = 1'b0;
    memtoReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluControl  = c_ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        aluSrcB    = 2'b01;
        w_ir_write = memReady;
        w_pc_en    = memReady;
      end
      S_DECODE: begin
        aluSrcB   = 2'b11;
        w_illegal = (w_decode_next == S_FETCH);
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        iorD      = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        memtoReg    = 1'b1;
      end
      // memWrite is held through the wait; the memory commits on memReady.
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        iorD        = 1'b1;
      end
      S_RTYPEEX: begin
        aluSrcA    = 1'b1;
        aluControl = w_funct_alu;
      end
      S_RTYPEWB: begin
        w_reg_write = 1'b1;
        regDest     = 1'b1;
      end
      S_BEQEX: begin
        aluSrcA    = 1'b1;
        aluControl = c_ALU_SUB;
        pcSrc      = 2'b01;
        w_pc_en    = zero;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        pcSrc   = 2'b10;
        w_pc_en = 1'b1;
      end
      default: begin
        aluSrcB = 2'b01;
      end
    endcase
  end

  // Strobes and requests are masked while reset is low so nothing commits
  // between the reset edge and the state register clearing.
  assign memReq   = w_mem_req   & rst_n;
  assign memWrite = w_mem_write & rst_n;
  assign irWrite  = w_ir_write  & rst_n;
  assign pcEn     = w_pc_en     & rst_n;
  assign regWrite = w_reg_write & rst_n;
  assign illegal  = w_illegal   & rst_n;
  assign state    = r_state;

endmodule
`default_nettype wire
